// File: rtl/aes_key_regs_axil.sv
// AXI4-Lite register file holding four AES-128 staging key words and a
// committed shadow key that feeds the cipher core.
module aes_key_regs_axil #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [127:0]                      key_o,
    output logic                              key_load_o,
    output logic                              key_valid_o
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic             rdy_en_q, rdy_en_d;
    logic             aw_full_q, aw_full_d;
    logic [2:0]       aw_idx_q, aw_idx_d;
    logic             w_full_q, w_full_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [3:0][31:0] stage_q, stage_d;
    logic [127:0]     key_q, key_d;
    logic             key_load_q, key_load_d;
    logic             key_valid_q, key_valid_d;
    logic             lock_q, lock_d;

    logic        aw_hs, w_hs, ar_hs, do_write;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    assign S_AXI_AWREADY = rdy_en_q && !aw_full_q && !bvalid_q;
    assign S_AXI_WREADY  = rdy_en_q && !w_full_q && !bvalid_q;
    assign S_AXI_ARREADY = rdy_en_q && !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign key_o         = key_q;
    assign key_load_o    = key_load_q;
    assign key_valid_o   = key_valid_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A channel arriving this cycle is bypassed so the write lands on the
    // same edge that completes the second handshake.
    assign wr_idx   = aw_full_q ? aw_idx_q : S_AXI_AWADDR[4:2];
    assign wr_data  = w_full_q ? w_data_q : S_AXI_WDATA;
    assign wr_strb  = w_full_q ? w_strb_q : S_AXI_WSTRB;
    assign do_write = (aw_full_q || aw_hs) && (w_full_q || w_hs) && !bvalid_q;

    always_comb begin
        rdy_en_d    = 1'b1;
        aw_full_d   = aw_full_q;
        aw_idx_d    = aw_idx_q;
        w_full_d    = w_full_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        stage_d     = stage_q;
        key_d       = key_q;
        key_load_d  = 1'b0;
        key_valid_d = key_valid_q;
        lock_d      = lock_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[4:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end

        if (do_write) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (wr_idx)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                    if (lock_q) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (wr_strb[b]) stage_d[wr_idx[1:0]][8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                end
                3'd4: begin
                    if (wr_strb[0]) begin
                        if (wr_data[1]) lock_d = 1'b1;
                        if (wr_data[0]) begin
                            key_d       = stage_q;
                            key_load_d  = 1'b1;
                            key_valid_d = 1'b1;
                        end
                    end
                end
                default: bresp_d = RESP_SLVERR;
            endcase
        end

        // Holding registers stay full until the response is taken, which
        // keeps AWREADY/WREADY low for the whole transaction.
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d  = 1'b0;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            case (S_AXI_ARADDR[4:2])
                3'd0, 3'd1, 3'd2, 3'd3: rdata_d = stage_q[S_AXI_ARADDR[3:2]];
                3'd4:                   rdata_d = 32'd0;
                3'd5:                   rdata_d = {30'd0, lock_q, key_valid_q};
                default: begin
                    rdata_d = 32'd0;
                    rresp_d = RESP_SLVERR;
                end
            endcase
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdy_en_q    <= 1'b0;
            aw_full_q   <= 1'b0;
            aw_idx_q    <= 3'd0;
            w_full_q    <= 1'b0;
            w_data_q    <= 32'd0;
            w_strb_q    <= 4'd0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
            rresp_q     <= 2'b00;
            stage_q     <= '0;
            key_q       <= 128'd0;
            key_load_q  <= 1'b0;
            key_valid_q <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            rdy_en_q    <= rdy_en_d;
            aw_full_q   <= aw_full_d;
            aw_idx_q    <= aw_idx_d;
            w_full_q    <= w_full_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            stage_q     <= stage_d;
            key_q       <= key_d;
            key_load_q  <= key_load_d;
            key_valid_q <= key_valid_d;
            lock_q      <= lock_d;
        end
    end
endmodule

// File: doc/aes_key_regs_axil.md
# aes_key_regs_axil

AXI4-Lite slave register file that holds the 128-bit AES key and presents it to the AES-128 datapath. Software writes four 32-bit key words, then commits them with a control write. The commit copies the words atomically into a shadow key register that drives the cipher core. The block sits between the processor-side AXI4-Lite interconnect and the AXIS AES-128 engine. It is the responder for the same master write/readback sequence the system test issues.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte-address width; covers the 0x00–0x1C map.
- ACLK  in  1  single clock; all logic is rising-edge.
- ARESETN  in  1  reset, asynchronous and active-low.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  5/3/1/1  write address channel; AWPROT is ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  5/3/1/1  read address channel; ARPROT is ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.
- key_o  out  128  committed key, {KEY3,KEY2,KEY1,KEY0}; KEY0 forms bits [31:0].
- key_load_o  out  1  one-cycle pulse in the cycle key_o takes a new value.
- key_valid_o  out  1  sticky flag: at least one commit has occurred since reset.

## Operation
- Register map (address bits [4:2]; bits [1:0] are ignored):
  - 0x00–0x0C: KEY0–KEY3, read/write staging words.
  - 0x10: CTRL, write-only.
    - bit0 LOAD: writing 1 commits the staging words; it self-clears.
    - bit1 LOCK: writing 1 sets the lock; only reset clears it.
    - CTRL reads return 0.
  - 0x14: STATUS, read-only. bit0 = key_valid_o, bit1 = lock.
  - 0x18–0x1C: unmapped.
- Write path:
  - AW and W are captured independently into holding registers, in either order or in the same cycle.
  - The write executes in the cycle after both holding registers are full.
  - WSTRB[n] enables byte n for KEY0–KEY3. CTRL acts only when WSTRB[0]=1.
- Write responses:
  - OKAY (2'b00) for a legal write.
  - SLVERR (2'b10) for a write to STATUS, a write to an unmapped address, or a write to KEY0–KEY3 while locked. None of these has any register effect.
  - A LOAD while locked still commits and returns OKAY.
- Commit: key_o is loaded from the staging words as they stand at the start of the commit cycle. key_load_o=1 for exactly that cycle. key_valid_o is set.
- Read path:
  - An AR handshake latches the address.
  - RDATA is registered from the current register values.
  - RRESP is OKAY for mapped addresses (including CTRL, which returns 0) and SLVERR with RDATA=0 for unmapped addresses.
- Read and write paths are fully independent.
  - A read and a write to the same KEY word in the same cycle return the pre-write value.
- Reset outputs (asynchronous):
  - All staging words, key_o, key_valid_o and lock are 0.
  - AWREADY, WREADY, ARREADY, BVALID, RVALID and key_load_o are 0.
  - BRESP, RRESP and RDATA are 0.
  - Any in-flight transaction is discarded.

## Timing
- AWREADY=1 while the AW holding register is empty and BVALID=0. The same rule applies to WREADY with the W holding register.
- Write latency:
  - Both handshakes in cycle N: the write takes effect and BVALID rises in cycle N+1.
  - AW in cycle N and W in cycle M: the response follows one cycle after max(N,M).
- Write response: BVALID is held with BRESP stable until BREADY. The holding registers clear in the B handshake cycle, and AWREADY/WREADY return to 1 on the next cycle.
- Read timing:
  - ARREADY=1 when RVALID=0 and no read is pending.
  - AR handshake in cycle N gives RVALID=1 in N+1.
  - RDATA/RRESP are held stable until RREADY. ARREADY deasserts while RVALID=1.
- Throughput: at most one write per two cycles and one read per two cycles.
- Commit timing: key_o changes, and key_load_o pulses, in the same cycle BVALID rises for the CTRL write.
- After ARESETN deasserts, READY signals rise on the first ACLK edge.

## Test plan
- Basic readback:
  - Stimulus: write 0x1, 0x2, 0x3, 0x4 to 0x00–0x0C, then read them back.
  - Response: each BRESP=OKAY; reads return 0x1–0x4 with RRESP=OKAY; key_o still 0; key_valid_o=0.
- Commit:
  - Stimulus: after the previous scenario, write 0x1 to 0x10.
  - Response: one-cycle key_load_o; key_o=0x00000004_00000003_00000002_00000001; STATUS reads 0x1.
- Byte strobes and channel order:
  - Stimulus: write 0xAABBCCDD to 0x00 with WSTRB=4'b0101, W presented two cycles before AW.
  - Response: KEY0 reads 0x00BB00DD starting from 0; BVALID one cycle after the AW handshake.
- Lock:
  - Stimulus: write 0x2 to 0x10, then 0xFFFFFFFF to 0x04.
  - Response: BRESP=SLVERR and KEY1 unchanged; STATUS=0x2.
  - Stimulus: write 0x1 to 0x10.
  - Response: commit still occurs with BRESP=OKAY.
- Error responses and backpressure:
  - Stimulus: read 0x18 and write 0x14, with BREADY/RREADY held low for 5 cycles.
  - Response: RRESP=SLVERR with RDATA=0; BRESP=SLVERR; BVALID, RVALID and their payloads stay stable throughout the stall; no new AWREADY before the B handshake.
- Reset mid-transaction:
  - Stimulus: drop ARESETN after the AW handshake, before W.
  - Response: all outputs go to their reset values immediately; after release, a fresh write to 0x00 completes normally and the stale AW is not used.
